rpi_sample_buffer: RTL

RPI_SAMPLE_BUFFER -- requirements
Module: rpi_sample_buffer

---
 rtl/rpi_sample_buffer_if.sv | 22 ++
 rtl/rpi_sample_buffer.sv | 87 ++++++++
 2 files changed

// File: rtl/rpi_sample_buffer_if.sv
// rpi_sample_buffer_if: stereo sample input and Raspberry Pi serial burst port.
interface rpi_sample_buffer_if #(
   parameter int SAMPLE_W = 16,
   parameter int DEPTH = 16
);
   logic [SAMPLE_W-1:0] sample_l;
   logic [SAMPLE_W-1:0] sample_r;
   logic sample_valid;
   logic rpi_clk;
   logic interrupt_enable;
   logic rpi_data;
   logic [$clog2(DEPTH):0] level;
   logic overflow;
   modport master (
      output sample_l, sample_r, sample_valid, rpi_clk,
      input interrupt_enable, rpi_data, level, overflow
   );
   modport slave (
      input sample_l, sample_r, sample_valid, rpi_clk,
      output interrupt_enable, rpi_data, level, overflow
   );
endinterface

// File: rtl/rpi_sample_buffer.sv
// rpi_sample_buffer: stereo frame FIFO drained to a Raspberry Pi in WATERMARK-frame serial bursts.
module rpi_sample_buffer #(
   parameter int SAMPLE_W = 16,
   parameter int DEPTH = 16,
   parameter int WATERMARK = 8
) (
   input logic clk_in,
   input logic reset,
   rpi_sample_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = 2 * SAMPLE_W;
   localparam int BW = $clog2(FW);
   typedef logic [AW:0] lvl_t;
   typedef logic [BW-1:0] bit_t;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t state;
   logic [FW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   lvl_t level;
   lvl_t frame_cnt;
   bit_t bit_cnt;
   logic [FW-1:0] sh;
   logic [2:0] sync;
   logic fall;
   logic overflow;
   logic ie;
   logic full;
   logic last_bit;
   logic last_frame;
   logic pop;
   logic wr;
   assign full = level == lvl_t'(DEPTH);
   assign last_bit = bit_cnt == bit_t'(FW - 1);
   assign last_frame = frame_cnt == lvl_t'(WATERMARK - 1);
   assign pop = state == LOAD || (state == SHIFT && fall && last_bit && !last_frame);
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the write
   assign wr = bus.sample_valid && (!full || pop);
   assign bus.level = level;
   assign bus.overflow = overflow;
   assign bus.interrupt_enable = ie;
   assign bus.rpi_data = state == SHIFT && sh[FW-1];
   always_ff @(posedge clk_in)
      if (wr) mem[wr_ptr] <= {bus.sample_l, bus.sample_r};
   always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
         overflow <= 1'b0;
         sh <= '0;
         bit_cnt <= '0;
         frame_cnt <= '0;
         sync <= '0;
         fall <= 1'b0;
         ie <= 1'b0;
      end else begin
         sync <= {sync[1:0], bus.rpi_clk};
         fall <= sync[2] & ~sync[1];
         wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
         level <= level + lvl_t'(wr) - lvl_t'(pop);
         overflow <= overflow | (bus.sample_valid & ~wr);
         sh <= pop ? mem[rd_ptr] : (state == SHIFT && fall) ? sh << 1 : sh;
         case (state)
            IDLE: state <= level >= lvl_t'(WATERMARK) ? LOAD : IDLE;
            LOAD: begin
               bit_cnt <= '0;
               frame_cnt <= '0;
               ie <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: if (fall) begin
               bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
               frame_cnt <= last_bit ? frame_cnt + 1'b1 : frame_cnt;
               ie <= !(last_bit && last_frame);
               state <= last_bit && last_frame ? DONE : SHIFT;
            end
            DONE: begin
               ie <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
endmodule
